interrupt_sequencer: RTL and testbench
======================================

Name: interrupt_sequencer

Overview:
CPU-side end of the coprocessor-0 interrupt handshake. Sits between the commit stage of the pipeline and the COP0 register block. It takes a pending InterruptRequest at a safe commit point, pulses InterruptHandled with the restart PC, and redirects and flushes the pipeline. It also executes ERET: it reads EPC and Status, rewrites Status with IE=1, and redirects to EPC. When idle it passes the pipeline's MTC0/MFC0 traffic straight through to COP0.

Parameters:
HANDLER_ADDR, 32'h0000_0180, interrupt vector loaded into RedirectPC on a take
FLUSH_CYCLES, 2, cycles Flush stays asserted after a redirect (>=1)

Ports:
Clock  in  1  clock
Reset  in  1  reset
Stall  in  1  pipeline stalled; blocks take/ERET decisions
CommitValid  in  1  valid instruction in commit stage
CommitPC  in  32  PC of commit-stage instruction
CommitInDelaySlot  in  1  commit instruction is in a branch delay slot
CommitIsEret  in  1  commit instruction is ERET
CpuCop0Address  in  5  pipeline COP0 register address
CpuCop0WriteEnable  in  1  pipeline MTC0 strobe
CpuCop0WriteData  in  32  pipeline MTC0 data
CpuCop0ReadData  out  32  COP0 read data returned to the pipeline
InterruptRequest  in  1  from COP0
InterruptHandled  out  1  to COP0; one-cycle pulse
InterruptedPC  out  32  to COP0; restart PC, captured into EPC
Cop0Address  out  5  to COP0 DataAddress
Cop0DataInEnable  out  1  to COP0 DataInEnable
Cop0DataIn  out  32  to COP0 DataIn
Cop0DataOut  in  32  from COP0 DataOut
Redirect  out  1  load RedirectPC into fetch PC
RedirectPC  out  32  redirect target
Flush  out  1  squash all in-flight instructions, including commit stage

Behaviour:
- Reset is synchronous and active-high on Clock. On Reset:
  - state = IDLE
  - InterruptedPC = 0, epc_q = 0, status_q = 0, flush count = 0
  - InterruptHandled, Redirect, Cop0DataInEnable = 0
  - Reset mid-sequence aborts the sequence with no further COP0 writes.
- States: IDLE, TRAP, ERET_EPC, ERET_STAT, ERET_WR, FLUSH.
- In IDLE, the COP0 bus is pass-through: Cop0Address=CpuCop0Address, Cop0DataInEnable=CpuCop0WriteEnable, Cop0DataIn=CpuCop0WriteData. CpuCop0ReadData=Cop0DataOut in all states.
- take (combinational) = IDLE & InterruptRequest & CommitValid & ~CommitInDelaySlot & ~CommitIsEret & ~CpuCop0WriteEnable & ~Stall.
- eret (combinational) = IDLE & CommitValid & CommitIsEret & ~Stall. ERET has priority; take excludes ERET.
- Flush = take | eret | (state != IDLE). The deciding instruction is squashed and not committed.
- On take:
  - InterruptedPC <= CommitPC; the instruction re-executes after the handler.
  - next state = TRAP.
- TRAP, one cycle: InterruptHandled=1, Redirect=1, RedirectPC=HANDLER_ADDR, Cop0DataInEnable=0. COP0 captures EPC and clears IE on this edge. Next state = FLUSH.
- On eret, next state = ERET_EPC.
  - ERET_EPC: Cop0Address=5'hE, Cop0DataInEnable=0; epc_q <= Cop0DataOut. Next state = ERET_STAT.
  - ERET_STAT: Cop0Address=5'hC, Cop0DataInEnable=0; status_q <= Cop0DataOut. Next state = ERET_WR.
  - ERET_WR, one cycle: Cop0Address=5'hC, Cop0DataInEnable=1, Cop0DataIn={status_q[31:1],1'b1}; Redirect=1, RedirectPC=epc_q. Next state = FLUSH.
- In non-IDLE states:
  - Cop0Address=0 and Cop0DataInEnable=0 except where specified above.
  - Pipeline COP0 writes are dropped.
- FLUSH holds for FLUSH_CYCLES cycles, counted from 0 to FLUSH_CYCLES-1, then returns to IDLE. InterruptRequest and CommitValid are ignored throughout FLUSH.
- Stall affects IDLE decisions only. Non-IDLE states always advance one state per cycle.
- InterruptRequest asserted while CommitInDelaySlot=1, or while CommitValid=0, is held off until the first qualifying commit cycle. No request is lost, because COP0 keeps IP latched.
- COP0 masks InterruptRequest while DataInEnable=1. The sequencer additionally refuses take whenever CpuCop0WriteEnable=1.
- Redirect and InterruptHandled are never asserted in the same cycle except in TRAP. Neither output asserts twice per sequence.
- InterruptedPC holds its value until the next take.

Test Plan:
- Reset, then InterruptRequest=1 with CommitValid=1, CommitPC=32'h0000_1040, no stall:
  - take cycle: Flush=1.
  - next cycle: InterruptHandled=1, InterruptedPC=32'h1040, Redirect=1, RedirectPC=32'h180.
  - Flush stays high for 2 more cycles, then the sequencer is back in IDLE.
- InterruptRequest=1 while CommitInDelaySlot=1 at PC 32'h2004:
  - no take in that cycle.
  - next commit, PC 32'h2008 and not in a delay slot: take with InterruptedPC=32'h2008.
- ERET at commit with COP0 EPC=32'h0000_3000 and Status=32'h0000_FC00:
  - Cop0Address sequence is E, C, C.
  - ERET_WR writes Cop0DataIn=32'h0000_FC01 with Cop0DataInEnable=1.
  - Redirect=1 with RedirectPC=32'h3000.
- Stall=1 with InterruptRequest=1 and CommitValid=1 for 5 cycles:
  - no take, Flush=0 throughout.
  - take occurs in the first cycle Stall=0.
- MTC0 to address 5'h9 with data 32'h55 in IDLE while InterruptRequest=1:
  - pass-through write is visible on Cop0Address, Cop0DataInEnable and Cop0DataIn.
  - no take in that cycle; take occurs the following qualifying cycle.
- Reset asserted during ERET_STAT:
  - next cycle state is IDLE.
  - Cop0DataInEnable stays 0 and Redirect stays 0; no Status write occurs.

Source files
------------

// File: rtl/interrupt_sequencer.sv
// interrupt_sequencer: CPU-side COP0 interrupt handshake and ERET sequencer.
// Takes interrupts at safe commit points, runs the ERET read/modify/write of
// Status, redirects and flushes the pipeline, and passes MTC0/MFC0 through when idle.
module interrupt_sequencer #(
  parameter logic [31:0] HANDLER_ADDR = 32'h0000_0180,
  parameter int unsigned FLUSH_CYCLES = 2
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        Stall,
  input  logic        CommitValid,
  input  logic [31:0] CommitPC,
  input  logic        CommitInDelaySlot,
  input  logic        CommitIsEret,
  input  logic [4:0]  CpuCop0Address,
  input  logic        CpuCop0WriteEnable,
  input  logic [31:0] CpuCop0WriteData,
  output logic [31:0] CpuCop0ReadData,
  input  logic        InterruptRequest,
  output logic        InterruptHandled,
  output logic [31:0] InterruptedPC,
  output logic [4:0]  Cop0Address,
  output logic        Cop0DataInEnable,
  output logic [31:0] Cop0DataIn,
  input  logic [31:0] Cop0DataOut,
  output logic        Redirect,
  output logic [31:0] RedirectPC,
  output logic        Flush
);

  localparam int unsigned CNT_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FLUSH_CYCLES - 1);

  localparam logic [4:0] ADDR_STATUS = 5'hC;
  localparam logic [4:0] ADDR_EPC    = 5'hE;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_TRAP,
    ST_ERET_EPC,
    ST_ERET_STAT,
    ST_ERET_WR,
    ST_FLUSH
  } state_t;

  state_t             state_q, state_d;
  logic [31:0]        interrupted_pc_q, interrupted_pc_d;
  logic [31:0]        epc_q, epc_d;
  logic [31:0]        status_q, status_d;
  logic [CNT_W-1:0]   flush_cnt_q, flush_cnt_d;
  logic               take, eret;

  assign CpuCop0ReadData = Cop0DataOut;
  assign InterruptedPC   = interrupted_pc_q;

  // State and captured-register update; synchronous active-high reset.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q          <= ST_IDLE;
      interrupted_pc_q <= '0;
      epc_q            <= '0;
      status_q         <= '0;
      flush_cnt_q      <= '0;
    end else begin
      state_q          <= state_d;
      interrupted_pc_q <= interrupted_pc_d;
      epc_q            <= epc_d;
      status_q         <= status_d;
      flush_cnt_q      <= flush_cnt_d;
    end
  end

  // Next-state, take/ERET decisions and COP0/pipeline outputs.
  always_comb begin
    state_d          = state_q;
    interrupted_pc_d = interrupted_pc_q;
    epc_d            = epc_q;
    status_d         = status_q;
    flush_cnt_d      = flush_cnt_q;
    take             = 1'b0;
    eret             = 1'b0;
    Cop0Address      = '0;
    Cop0DataInEnable = 1'b0;
    Cop0DataIn       = '0;
    InterruptHandled = 1'b0;
    Redirect         = 1'b0;
    RedirectPC       = '0;
    Flush            = (state_q != ST_IDLE);

    case (state_q)
      ST_IDLE: begin
        Cop0Address      = CpuCop0Address;
        Cop0DataInEnable = CpuCop0WriteEnable;
        Cop0DataIn       = CpuCop0WriteData;
        eret = CommitValid & CommitIsEret & ~Stall;
        take = InterruptRequest & CommitValid & ~CommitInDelaySlot & ~CommitIsEret
             & ~CpuCop0WriteEnable & ~Stall;
        Flush = take | eret;
        if (eret) begin
          state_d = ST_ERET_EPC;
        end else if (take) begin
          interrupted_pc_d = CommitPC;
          state_d          = ST_TRAP;
        end
      end
      ST_TRAP: begin
        InterruptHandled = 1'b1;
        Redirect         = 1'b1;
        RedirectPC       = HANDLER_ADDR;
        flush_cnt_d      = '0;
        state_d          = ST_FLUSH;
      end
      ST_ERET_EPC: begin
        Cop0Address = ADDR_EPC;
        epc_d       = Cop0DataOut;
        state_d     = ST_ERET_STAT;
      end
      ST_ERET_STAT: begin
        Cop0Address = ADDR_STATUS;
        status_d    = Cop0DataOut;
        state_d     = ST_ERET_WR;
      end
      ST_ERET_WR: begin
        Cop0Address      = ADDR_STATUS;
        Cop0DataInEnable = 1'b1;
        Cop0DataIn       = {status_q[31:1], 1'b1};
        Redirect         = 1'b1;
        RedirectPC       = epc_q;
        flush_cnt_d      = '0;
        state_d          = ST_FLUSH;
      end
      ST_FLUSH: begin
        if (flush_cnt_q == CNT_LAST) begin
          flush_cnt_d = '0;
          state_d     = ST_IDLE;
        end else begin
          flush_cnt_d = flush_cnt_q + CNT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_interrupt_sequencer.sv
// Self-checking bench for interrupt_sequencer: per-cycle expected outputs are
// queued as stimulus is driven and compared when the cycle's outputs settle.
module tb_interrupt_sequencer;

  logic        Clock = 1'b0;
  logic        Reset, Stall, CommitValid, CommitInDelaySlot, CommitIsEret;
  logic [31:0] CommitPC;
  logic [4:0]  CpuCop0Address;
  logic        CpuCop0WriteEnable;
  logic [31:0] CpuCop0WriteData, CpuCop0ReadData;
  logic        InterruptRequest, InterruptHandled;
  logic [31:0] InterruptedPC;
  logic [4:0]  Cop0Address;
  logic        Cop0DataInEnable;
  logic [31:0] Cop0DataIn, Cop0DataOut;
  logic        Redirect;
  logic [31:0] RedirectPC;
  logic        Flush;

  int unsigned checks = 0;
  int unsigned errors = 0;

  typedef struct {
    string       tag;
    logic        flush, hnd, red;
    logic [31:0] rpc;
    logic [4:0]  addr;
    logic        we;
    logic [31:0] din;
    logic        ipc_chk;
    logic [31:0] ipc;
  } exp_t;

  exp_t sb[$];

  interrupt_sequencer #(.HANDLER_ADDR(32'h0000_0180), .FLUSH_CYCLES(2)) dut (
    .Clock(Clock), .Reset(Reset), .Stall(Stall), .CommitValid(CommitValid),
    .CommitPC(CommitPC), .CommitInDelaySlot(CommitInDelaySlot), .CommitIsEret(CommitIsEret),
    .CpuCop0Address(CpuCop0Address), .CpuCop0WriteEnable(CpuCop0WriteEnable),
    .CpuCop0WriteData(CpuCop0WriteData), .CpuCop0ReadData(CpuCop0ReadData),
    .InterruptRequest(InterruptRequest), .InterruptHandled(InterruptHandled),
    .InterruptedPC(InterruptedPC), .Cop0Address(Cop0Address),
    .Cop0DataInEnable(Cop0DataInEnable), .Cop0DataIn(Cop0DataIn),
    .Cop0DataOut(Cop0DataOut), .Redirect(Redirect), .RedirectPC(RedirectPC), .Flush(Flush)
  );

  always #5 Clock = ~Clock;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h want %h", tag, got, want);
    end
  endtask

  function automatic exp_t ex(input string tag, input logic flush, input logic hnd,
                              input logic red, input logic [31:0] rpc, input logic [4:0] addr,
                              input logic we, input logic [31:0] din,
                              input logic ipc_chk, input logic [31:0] ipc);
    exp_t e;
    e.tag = tag; e.flush = flush; e.hnd = hnd; e.red = red; e.rpc = rpc;
    e.addr = addr; e.we = we; e.din = din; e.ipc_chk = ipc_chk; e.ipc = ipc;
    return e;
  endfunction

  // Quiet-pipeline input defaults
  task automatic quiet();
    Stall = 0; CommitValid = 0; CommitPC = '0; CommitInDelaySlot = 0; CommitIsEret = 0;
    CpuCop0Address = '0; CpuCop0WriteEnable = 0; CpuCop0WriteData = '0;
    InterruptRequest = 0; Cop0DataOut = '0;
  endtask

  // Queue this cycle's expectation, then compare once outputs settle
  task automatic step(input exp_t e);
    exp_t x;
    sb.push_back(e);
    @(negedge Clock);
    x = sb.pop_front();
    check({x.tag, ".flush"}, 32'(Flush), 32'(x.flush));
    check({x.tag, ".handled"}, 32'(InterruptHandled), 32'(x.hnd));
    check({x.tag, ".redirect"}, 32'(Redirect), 32'(x.red));
    if (x.red) check({x.tag, ".rpc"}, RedirectPC, x.rpc);
    check({x.tag, ".addr"}, 32'(Cop0Address), 32'(x.addr));
    check({x.tag, ".we"}, 32'(Cop0DataInEnable), 32'(x.we));
    if (x.we) check({x.tag, ".din"}, Cop0DataIn, x.din);
    if (x.ipc_chk) check({x.tag, ".ipc"}, InterruptedPC, x.ipc);
    check({x.tag, ".rdata"}, CpuCop0ReadData, Cop0DataOut);
    @(posedge Clock);
    #1;
  endtask

  // TRAP cycle then both FLUSH cycles, with pipeline noise that must be ignored
  task automatic trap_tail(input string tag, input logic [31:0] pc);
    InterruptRequest = 1; CommitValid = 1; CommitPC = 32'hDEAD_0000;
    step(ex({tag, ".trap"}, 1, 1, 1, 32'h180, 5'h0, 0, '0, 1, pc));
    CpuCop0WriteEnable = 1; CpuCop0Address = 5'h9; CpuCop0WriteData = 32'h77;
    step(ex({tag, ".fl0"}, 1, 0, 0, '0, 5'h0, 0, '0, 1, pc));
    step(ex({tag, ".fl1"}, 1, 0, 0, '0, 5'h0, 0, '0, 1, pc));
    quiet();
    step(ex({tag, ".idle"}, 0, 0, 0, '0, 5'h0, 0, '0, 1, pc));
  endtask

  initial begin
    quiet();
    Reset = 1;
    @(posedge Clock); #1;
    step(ex("reset", 0, 0, 0, '0, 5'h0, 0, '0, 1, 32'h0));
    Reset = 0;
    step(ex("post_reset", 0, 0, 0, '0, 5'h0, 0, '0, 1, 32'h0));

    // Basic take
    InterruptRequest = 1; CommitValid = 1; CommitPC = 32'h0000_1040;
    step(ex("t1.take", 1, 0, 0, '0, 5'h0, 0, '0, 0, '0));
    trap_tail("t1", 32'h0000_1040);

    // Delay slot holds off the take
    InterruptRequest = 1; CommitValid = 1; CommitPC = 32'h2004; CommitInDelaySlot = 1;
    step(ex("t2.ds", 0, 0, 0, '0, 5'h0, 0, '0, 1, 32'h1040));
    CommitPC = 32'h2008; CommitInDelaySlot = 0;
    step(ex("t2.take", 1, 0, 0, '0, 5'h0, 0, '0, 0, '0));
    trap_tail("t2", 32'h2008);

    // CommitValid low holds off the take
    InterruptRequest = 1; CommitValid = 0; CommitPC = 32'h2100;
    step(ex("t2b.nv", 0, 0, 0, '0, 5'h0, 0, '0, 1, 32'h2008));
    CommitValid = 1;
    step(ex("t2b.take", 1, 0, 0, '0, 5'h0, 0, '0, 0, '0));
    trap_tail("t2b", 32'h2100);

    // ERET, with a simultaneous interrupt request that must lose
    CommitValid = 1; CommitIsEret = 1; InterruptRequest = 1; CommitPC = 32'h2200;
    step(ex("t3.eret", 1, 0, 0, '0, 5'h0, 0, '0, 1, 32'h2100));
    quiet(); Cop0DataOut = 32'h0000_3000;
    step(ex("t3.epc", 1, 0, 0, '0, 5'hE, 0, '0, 1, 32'h2100));
    Cop0DataOut = 32'h0000_FC00;
    step(ex("t3.stat", 1, 0, 0, '0, 5'hC, 0, '0, 0, '0));
    Cop0DataOut = 32'h1234_5678;
    step(ex("t3.wr", 1, 0, 1, 32'h3000, 5'hC, 1, 32'h0000_FC01, 1, 32'h2100));
    step(ex("t3.fl0", 1, 0, 0, '0, 5'h0, 0, '0, 0, '0));
    step(ex("t3.fl1", 1, 0, 0, '0, 5'h0, 0, '0, 0, '0));
    step(ex("t3.idle", 0, 0, 0, '0, 5'h0, 0, '0, 0, '0));

    // Stall blocks the take for five cycles
    Stall = 1; InterruptRequest = 1; CommitValid = 1; CommitPC = 32'h4000;
    for (int i = 0; i < 5; i++)
      step(ex("t4.stall", 0, 0, 0, '0, 5'h0, 0, '0, 1, 32'h2100));
    Stall = 0;
    step(ex("t4.take", 1, 0, 0, '0, 5'h0, 0, '0, 0, '0));
    trap_tail("t4", 32'h4000);

    // MTC0 pass-through blocks the take for that cycle
    InterruptRequest = 1; CommitValid = 1; CommitPC = 32'h5000;
    CpuCop0WriteEnable = 1; CpuCop0Address = 5'h9; CpuCop0WriteData = 32'h55;
    Cop0DataOut = 32'hA5A5_0001;
    step(ex("t5.mtc0", 0, 0, 0, '0, 5'h9, 1, 32'h55, 1, 32'h4000));
    CpuCop0WriteEnable = 0; CpuCop0Address = 5'h0;
    step(ex("t5.take", 1, 0, 0, '0, 5'h0, 0, '0, 0, '0));
    trap_tail("t5", 32'h5000);

    // Reset during ERET_STAT aborts with no Status write
    CommitValid = 1; CommitIsEret = 1;
    step(ex("t6.eret", 1, 0, 0, '0, 5'h0, 0, '0, 0, '0));
    quiet(); Cop0DataOut = 32'h0000_6000;
    step(ex("t6.epc", 1, 0, 0, '0, 5'hE, 0, '0, 0, '0));
    Reset = 1; Cop0DataOut = 32'h0000_FC00;
    step(ex("t6.stat", 1, 0, 0, '0, 5'hC, 0, '0, 0, '0));
    Reset = 0; Cop0DataOut = '0;
    step(ex("t6.after", 0, 0, 0, '0, 5'h0, 0, '0, 1, 32'h0));
    step(ex("t6.after2", 0, 0, 0, '0, 5'h0, 0, '0, 1, 32'h0));

    check("sb.empty", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
